// File: rtl/rollback_sequencer_if.sv
// Fault-voter / rollback handshake bundle between the recovery sequencer and the core.
// master = sequencer side, slave = core/voter side.
interface rollback_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       Voter_state;
  logic [31:0]      RD_Instr;
  logic             rollback_ready;
  logic             core_hold;
  logic             Recovery_mode;
  logic             Mux_Instr_sel;
  logic             Mux_Data_sel;
  logic             rollback_valid;
  logic [31:0]      Rollback_instr;
  logic             recovery_done;
  logic             double_fault;
  logic [CNT_W-1:0] fault_count;

  modport master (
    input  Voter_state, RD_Instr, rollback_ready,
    output core_hold, Recovery_mode, Mux_Instr_sel, Mux_Data_sel,
           rollback_valid, Rollback_instr, recovery_done, double_fault, fault_count
  );

  modport slave (
    output Voter_state, RD_Instr, rollback_ready,
    input  core_hold, Recovery_mode, Mux_Instr_sel, Mux_Data_sel,
           rollback_valid, Rollback_instr, recovery_done, double_fault, fault_count
  );
endinterface

// File: rtl/rollback_sequencer.sv
// On a voter disagreement, replays golden-memory loads for the rd/rs1/rs2 of the
// faulting instruction, drains the pipeline, then releases the cores.
module rollback_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input logic             clk,
  input logic             rst_in,
  rollback_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RST_RD, RST_RS1, RST_RS2, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             df_q, df_d;
  logic             hold_q, hold_d;
  logic             mode_q, mode_d;
  logic             isel_q, isel_d;
  logic             dsel_q, dsel_d;
  logic             vld_q, vld_d;
  logic [31:0]      rinstr_q, rinstr_d;
  logic             done_q, done_d;

  logic       fault;
  logic [4:0] cur_field, nxt_field;
  logic       restoring;

  function automatic logic [4:0] field_of(input state_e s, input logic [31:0] ins);
    case (s)
      RST_RD:  return ins[11:7];
      RST_RS1: return ins[19:15];
      RST_RS2: return ins[24:20];
      default: return 5'd0;
    endcase
  endfunction

  // ld xr, r(x0): golden data memory mirrors the register file at address r
  function automatic logic [31:0] restore_op(input logic [4:0] r);
    return {7'b0, r, 5'd0, 3'b011, r, 7'b0000011};
  endfunction

  assign fault     = (bus.Voter_state != 3'b111);
  assign cur_field = field_of(state_q, instr_q);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      drain_q  <= '0;
      cnt_q    <= '0;
      df_q     <= 1'b0;
      hold_q   <= 1'b0;
      mode_q   <= 1'b0;
      isel_q   <= 1'b0;
      dsel_q   <= 1'b0;
      vld_q    <= 1'b0;
      rinstr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      df_q     <= df_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      isel_q   <= isel_d;
      dsel_q   <= dsel_d;
      vld_q    <= vld_d;
      rinstr_q <= rinstr_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    df_d    = df_q;
    // A fault while already recovering is only recorded, never recaptured
    if (state_q != IDLE && fault) df_d = 1'b1;
    case (state_q)
      IDLE: if (fault) begin
        instr_d = bus.RD_Instr;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = RST_RD;
      end
      RST_RD:  if (cur_field == 5'd0 || (vld_q && bus.rollback_ready)) state_d = RST_RS1;
      RST_RS1: if (cur_field == 5'd0 || (vld_q && bus.rollback_ready)) state_d = RST_RS2;
      RST_RS2: if (cur_field == 5'd0 || (vld_q && bus.rollback_ready)) begin
        state_d = DRAIN;
        drain_d = 4'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (drain_q == 4'd0) state_d = DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge
  always_comb begin
    nxt_field = field_of(state_d, instr_d);
    restoring = (state_d == RST_RD) || (state_d == RST_RS1) || (state_d == RST_RS2);
    hold_d    = restoring || (state_d == DRAIN);
    mode_d    = hold_d;
    isel_d    = restoring;
    dsel_d    = restoring;
    vld_d     = restoring && (nxt_field != 5'd0);
    rinstr_d  = vld_d ? restore_op(nxt_field) : 32'd0;
    done_d    = (state_d == DONE);
  end

  assign bus.core_hold      = hold_q;
  assign bus.Recovery_mode  = mode_q;
  assign bus.Mux_Instr_sel  = isel_q;
  assign bus.Mux_Data_sel   = dsel_q;
  assign bus.rollback_valid = vld_q;
  assign bus.Rollback_instr = rinstr_q;
  assign bus.recovery_done  = done_q;
  assign bus.double_fault   = df_q;
  assign bus.fault_count    = cnt_q;

endmodule

// File: tb/tb_rollback_sequencer.sv
// Bench for rollback_sequencer: directed table, multi-cycle corner sequences and
// random traffic against a phase-list reference model.
module tb_rollback_sequencer;
  localparam int DC = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk = ~clk;

  rollback_sequencer_if #(.CNT_W(CW)) bus();
  rollback_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (.clk(clk), .rst_in(rst_in), .bus(bus));

  int checks = 0, errors = 0;
  int n_vld, n_done, n_hold, n_a03, done_at, stepno;

  // Recovery as a list of remaining phases: 0..31 restore reg r, 100 drain cycle, 200 done
  int q[$];
  bit m_df;
  int m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_op(input int r);
    logic [4:0] f;
    f = r[4:0];
    return {7'b0, f, 5'd0, 3'b011, f, 7'b0000011};
  endfunction

  task automatic model_reset();
    q.delete();
    m_df  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic [2:0] v, input logic [31:0] ins, input logic rdy);
    bit f;
    f = (v != 3'b111);
    if (q.size() == 0) begin
      if (f) begin
        q.push_back(int'(ins[11:7]));
        q.push_back(int'(ins[19:15]));
        q.push_back(int'(ins[24:20]));
        for (int i = 0; i < DC; i++) q.push_back(100);
        q.push_back(200);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end else begin
      if (f) m_df = 1'b1;
      if (q[0] >= 32 || q[0] == 0 || rdy) void'(q.pop_front());
    end
  endtask

  task automatic model_check();
    int fr;
    bit rest, hold, vld;
    fr   = (q.size() == 0) ? -1 : q[0];
    rest = (fr >= 0 && fr < 32);
    hold = rest || (fr == 100);
    vld  = rest && (fr != 0);
    chk("core_hold", bus.core_hold, hold);
    chk("Recovery_mode", bus.Recovery_mode, hold);
    chk("Mux_Instr_sel", bus.Mux_Instr_sel, rest);
    chk("Mux_Data_sel", bus.Mux_Data_sel, rest);
    chk("rollback_valid", bus.rollback_valid, vld);
    if (vld) chk("Rollback_instr", bus.Rollback_instr, ld_op(fr));
    chk("recovery_done", bus.recovery_done, fr == 200);
    chk("double_fault", bus.double_fault, m_df);
    chk("fault_count", bus.fault_count, m_cnt);
  endtask

  task automatic step(input logic [2:0] v, input logic [31:0] ins, input logic rdy);
    bus.Voter_state    = v;
    bus.RD_Instr       = ins;
    bus.rollback_ready = rdy;
    @(posedge clk);
    model_edge(v, ins, rdy);
    #1;
    model_check();
    if (bus.rollback_valid) n_vld++;
    if (bus.core_hold) n_hold++;
    if (bus.recovery_done) begin n_done++; done_at = stepno; end
    if (bus.rollback_valid && bus.Rollback_instr == 32'h00A03503) n_a03++;
    stepno++;
  endtask

  task automatic clr_cnt();
    n_vld = 0; n_done = 0; n_hold = 0; n_a03 = 0; done_at = -1; stepno = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    bus.Voter_state    = 3'b111;
    bus.RD_Instr       = 32'd0;
    bus.rollback_ready = 1'b0;
    #12;
    model_reset();
    model_check();
    chk("rst_Rollback_instr", bus.Rollback_instr, 32'd0);
    rst_in = 1'b1;
    #2;
    clr_cnt();
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [31:0] ins;
    logic        rdy;
    logic        hold;
    logic        vld;
    logic [31:0] ri;
    logic        done;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rins;
    // Basic recovery of add x10,x10,x11 with ready always high; RD_Instr changes after capture
    tbl[0] = '{3'b110, 32'h00B50533, 1'b1, 1'b1, 1'b1, 32'h00A03503, 1'b0};
    tbl[1] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00A03503, 1'b0};
    tbl[2] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00B03583, 1'b0};
    tbl[3] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[4] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[5] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[6] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[7] = '{3'b111, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

    model_reset();
    clr_cnt();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].ins, tbl[i].rdy);
      chk($sformatf("tbl%0d_hold", i), bus.core_hold, tbl[i].hold);
      chk($sformatf("tbl%0d_valid", i), bus.rollback_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d_instr", i), bus.Rollback_instr, tbl[i].ri);
      chk($sformatf("tbl%0d_done", i), bus.recovery_done, tbl[i].done);
    end
    chk("tbl_fault_count", bus.fault_count, 1);
    chk("tbl_done_pulses", n_done, 1);

    // rs1 restore stalled by 4 cycles of ready low
    do_reset();
    step(3'b110, 32'h00B50533, 1'b1);
    step(3'b111, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(3'b111, 32'h0, 1'b0);
    step(3'b111, 32'h0, 1'b1);
    chk("stall_rs2_instr", bus.Rollback_instr, 32'h00B03583);
    for (int i = 0; i < 6; i++) step(3'b111, 32'h0, 1'b1);
    chk("stall_a03_cycles", n_a03, 6);
    chk("stall_done_pulses", n_done, 1);

    // No-register instruction: straight through drain, ready high throughout is ignored
    do_reset();
    step(3'b101, 32'h00000013, 1'b1);
    for (int i = 0; i < 8; i++) step(3'b111, 32'h0, 1'b1);
    chk("nop_valid_cycles", n_vld, 0);
    chk("nop_hold_cycles", n_hold, 6);
    chk("nop_done_at", done_at, 6);

    // Second fault during drain
    do_reset();
    step(3'b110, 32'h00B50533, 1'b1);
    for (int i = 1; i < 12; i++) step((i == 4) ? 3'b011 : 3'b111, 32'h0, 1'b1);
    chk("df_flag", bus.double_fault, 1);
    chk("df_count", bus.fault_count, 1);
    chk("df_done_pulses", n_done, 1);

    // Asynchronous reset in the middle of the rs1 restore
    do_reset();
    step(3'b110, 32'h00B50533, 1'b1);
    step(3'b111, 32'h0, 1'b1);
    bus.rollback_ready = 1'b0;
    #3;
    rst_in = 1'b0;
    #1;
    chk("ar_core_hold", bus.core_hold, 0);
    chk("ar_mode", bus.Recovery_mode, 0);
    chk("ar_isel", bus.Mux_Instr_sel, 0);
    chk("ar_dsel", bus.Mux_Data_sel, 0);
    chk("ar_valid", bus.rollback_valid, 0);
    chk("ar_instr", bus.Rollback_instr, 0);
    chk("ar_count", bus.fault_count, 0);
    model_reset();
    #1;
    rst_in = 1'b1;
    clr_cnt();
    for (int i = 0; i < 10; i++) step(3'b111, 32'h0, 1'b1);
    chk("ar_done_pulses", n_done, 0);

    // Back-to-back recoveries saturate the counter
    do_reset();
    for (int k = 0; k < 256; k++) begin
      step(3'b001, 32'h00000013, 1'b1);
      for (int i = 0; i < 7; i++) step(3'b111, 32'h0, 1'b1);
    end
    chk("sat_count", bus.fault_count, 8'hFF);
    chk("sat_done_pulses", n_done, 256);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rins = $urandom;
      if ($urandom_range(2) == 0) rins[11:7]  = 5'd0;
      if ($urandom_range(2) == 0) rins[19:15] = 5'd0;
      if ($urandom_range(2) == 0) rins[24:20] = 5'd0;
      step(($urandom_range(5) == 0) ? 3'($urandom_range(6)) : 3'b111, rins,
           1'($urandom_range(2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rollback_sequencer.md
ROLLBACK_SEQUENCER -- requirements
Module: rollback_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: hold cycles after the last restore before release (range 1..15).
REQ-002 Parameter CNT_W, default 8: width of the fault counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-low.
REQ-005 Voter_state  input  3  per-core agreement flags; 3'b111 means all agree, any other value means fault.
REQ-006 RD_Instr  input  32  instruction in flight at fault time, sampled on capture.
REQ-007 rollback_ready  input  1  the core instruction port accepts rollback_instr this cycle.
REQ-008 core_hold  output  1  stalls fetch/PC of all cores.
REQ-009 Recovery_mode  output  1  high from capture through release.
REQ-010 Mux_Instr_sel  output  1  selects rollback_instr into the core instruction path.
REQ-011 Mux_Data_sel  output  1  selects the golden data memory for restore loads.
REQ-012 rollback_valid  output  1  rollback_instr is valid.
REQ-013 Rollback_instr  output  32  restore instruction.
REQ-014 recovery_done  output  1  one-cycle pulse on release.
REQ-015 double_fault  output  1  sticky; a fault was seen while recovering.
REQ-016 fault_count  output  CNT_W  number of recoveries started, saturating.

Function
REQ-017 FSM states: IDLE, RST_RD, RST_RS1, RST_RS2, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: when Voter_state != 3'b111 is sampled, latch RD_Instr, increment fault_count (saturating at all-ones), and go to RST_RD.
REQ-019 Fault sampled at edge N: core_hold, Recovery_mode, Mux_Instr_sel, Mux_Data_sel and rollback_valid are all high from edge N onward (1-cycle latency).
REQ-020 Restore instruction for register r: imm[11:0]={7'b0,r}, rs1=x0, funct3=3'b011, rd=r, opcode 7'b0000011.
REQ-021 RST_RD, RST_RS1 and RST_RS2 use latched bits [11:7], [19:15] and [24:20] respectively.
REQ-022 Each restore state skips to the next state in 1 cycle, with rollback_valid low, when its field is 5'd0.
REQ-023 Handshake: rollback_valid is held and Rollback_instr is stable until rollback_valid&&rollback_ready; the state advances on that edge; there is no timeout.
REQ-024 rollback_ready asserted while rollback_valid is low is ignored.
REQ-025 After RST_RS2 go to DRAIN: Mux_Instr_sel, Mux_Data_sel and rollback_valid are low; core_hold and Recovery_mode stay high for exactly DRAIN_CYCLES cycles (down-counter).
REQ-026 DONE lasts 1 cycle: recovery_done=1; core_hold and Recovery_mode are low; next state is IDLE.
REQ-027 A fault sampled in any state other than IDLE sets double_fault; the sequence is neither restarted nor recaptured; fault_count is unchanged.
REQ-028 A fault present in the cycle after DONE (back in IDLE) starts a new recovery normally.
REQ-029 double_fault clears only on reset.

Reset
REQ-030 When rst_in=0, asynchronously: state goes to IDLE; all 1-bit outputs are 0; Rollback_instr=0; fault_count=0; the latched instruction and drain counter are 0.
REQ-031 Reset mid-recovery aborts immediately with no recovery_done pulse.
REQ-032 After rst_in rises, the first fault can be sampled on the first rising clk.

Verification
REQ-033 RD_Instr=0x00B50533, fault for 1 cycle, rollback_ready=1 -> Rollback_instr sequence 0x00A03503, 0x00A03503, 0x00B03583 on consecutive cycles; DRAIN lasts 3 cycles; recovery_done pulses once; fault_count=1.
REQ-034 Same stimulus with rollback_ready held low 4 cycles during RST_RS1 -> 0x00A03503 is held stable and valid for 5 cycles; the remaining sequence is unchanged.
REQ-035 RD_Instr=0x00000013 (addi x0,x0,0) -> no rollback_valid cycles; state goes directly through DRAIN to DONE in 3+3+1 cycles.
REQ-036 A second fault during DRAIN -> double_fault=1 and stays 1; fault_count stays 1; recovery_done still pulses.
REQ-037 rst_in pulsed low during RST_RS1 -> all outputs are 0 within the same cycle (asynchronously); no recovery_done pulse.
REQ-038 256 back-to-back recoveries with CNT_W=8 -> fault_count saturates at 8'hFF.
